mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter WAIT_EN, default 1: 1 = honour MemReady stalls; 0 = treat MemReady as always 1.
REQ-002 SHALL have ports `clk` (in, 1) and `reset` (in, 1); one clock; `reset` is asynchronous and active-low.
REQ-003 SHALL have inputs Cond (4, Instr[31:28]), Op (2, Instr[27:26]), Funct (6, Instr[25:20]), Rd (4, Instr[15:12]), ALUFlags (4, NZCV from ALU), MemReady (1, memory access complete).
REQ-004 SHALL have strobe outputs PCWrite, IRWrite, RegWrite, MemWrite (1 each).
REQ-005 SHALL have select outputs AdrSrc (1), ALUSrcA (1), ALUSrcB (2), ResultSrc (2), ImmSrc (2), RegSrc (2), ALUControl (2), and debug output State (4).

Function
REQ-006 SHALL implement a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL return to FETCH.
REQ-007 FETCH SHALL: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, IRWrite=1, PCWrite=1; hold in FETCH with both strobes 0 while MemReady=0.
REQ-008 DECODE SHALL: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; next state is MEMADR for Op=01, BRANCH for Op=10, EXECI for Op=00 with Funct[5]=1, EXECR for Op=00 with Funct[5]=0, and FETCH for Op=11.
REQ-009 MEMADR SHALL: ALUSrcA=0, ALUSrcB=01, ALUControl=00; next state MEMRD if Funct[0]=1, else MEMWR.
REQ-010 MEMRD SHALL: AdrSrc=1; hold while MemReady=0; then go to MEMWB.
REQ-011 MEMWB SHALL: ResultSrc=01, RegWrite=CondEx; next state FETCH.
REQ-012 MEMWR SHALL: AdrSrc=1, MemWrite=CondEx for exactly the first cycle in the state; hold while MemReady=0; then go to FETCH.
REQ-013 EXECR/EXECI SHALL: ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI), ALUControl decoded; next state ALUWB.
REQ-014 ALUWB SHALL: ResultSrc=00, RegWrite=CondEx & supported; PCWrite=CondEx & (Rd==15); next state FETCH.
REQ-015 BRANCH SHALL: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx; next state FETCH.
REQ-016 ALU decode from Funct[4:1] SHALL be: 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11; any other command is unsupported, with ALUControl=00 and no register or flag write.
REQ-017 ImmSrc SHALL equal Op; RegSrc[0] SHALL be (Op==10); RegSrc[1] SHALL be (Op==01); all are combinational from the instruction fields in every state.
REQ-018 The NZCV flag register SHALL update only in the EXECR/EXECI cycle, when Funct[0]=1, CondEx=1 and the command is supported: NZ always; CV only for ADD/SUB.
REQ-019 CondEx SHALL evaluate Cond against the registered flags using the standard ARM table (EQ..LE, AL=1110 true); Cond=1111 SHALL evaluate false.
REQ-020 Latency with MemReady=1 SHALL be: data-processing 4 cycles, LDR 5, STR 4, B 3, Op=11 2.

Reset
REQ-021 Asserting `reset` low SHALL immediately force State=FETCH and flags=0000, and SHALL force PCWrite, IRWrite, RegWrite and MemWrite to 0 while `reset` is low.
REQ-022 While `reset` is low, select outputs SHALL show FETCH values.
REQ-023 Reset asserted mid-instruction SHALL abort the instruction with no pending write; the first cycle after release SHALL be FETCH.

Structure
REQ-024 Package mc_pkg SHALL hold the state enum, the ALUControl encodings, the Funct command codes and the Cond codes.
REQ-025 Sub-module cond_unit SHALL contain the flag register and the CondEx evaluation; mc_controller SHALL contain the FSM and the decode.

Verification
REQ-026 ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000), MemReady=1 -> states 0,1,6,8,0; RegWrite=1 in cycle 4; flags unchanged.
REQ-027 SUBS with ALUFlags=0100 -> flags=0100 after EXECR; a following BEQ -> PCWrite=1 in BRANCH; BNE -> PCWrite=0.
REQ-028 LDR with MemReady low for 3 cycles in MEMRD -> State=3 held 4 cycles; RegWrite=1 once in MEMWB; total 8 cycles.
REQ-029 STR with Cond=1111 -> MemWrite never asserted; 4 cycles; returns to FETCH.
REQ-030 ADD with Rd=15 -> PCWrite=1 and RegWrite=1 in ALUWB.
REQ-031 reset pulled low during MEMWR with MemReady=0 -> MemWrite=0 immediately; State=0; flags=0000.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states, ALU control codes,
// data-processing command codes and condition codes.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9
    } state_e;

    localparam logic [1:0] OpDp   = 2'b00;
    localparam logic [1:0] OpMem  = 2'b01;
    localparam logic [1:0] OpBr   = 2'b10;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluAnd = 2'b10;
    localparam logic [1:0] AluOrr = 2'b11;

    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdOrr = 4'b1100;

    localparam logic [3:0] CondEq = 4'h0;
    localparam logic [3:0] CondNe = 4'h1;
    localparam logic [3:0] CondCs = 4'h2;
    localparam logic [3:0] CondCc = 4'h3;
    localparam logic [3:0] CondMi = 4'h4;
    localparam logic [3:0] CondPl = 4'h5;
    localparam logic [3:0] CondVs = 4'h6;
    localparam logic [3:0] CondVc = 4'h7;
    localparam logic [3:0] CondHi = 4'h8;
    localparam logic [3:0] CondLs = 4'h9;
    localparam logic [3:0] CondGe = 4'hA;
    localparam logic [3:0] CondLt = 4'hB;
    localparam logic [3:0] CondGt = 4'hC;
    localparam logic [3:0] CondLe = 4'hD;
    localparam logic [3:0] CondAl = 4'hE;
    localparam logic [3:0] CondNv = 4'hF;

    function automatic logic cmd_is_arith(input logic [3:0] cmd);
        return (cmd == CmdAdd) || (cmd == CmdSub);
    endfunction

endpackage

// File: rtl/mc_if.sv
// Instruction-field inputs and control outputs of the multicycle controller.
interface mc_if;

    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       MemReady;

    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] ALUControl;
    logic [3:0] State;

    modport master (
        output Cond, Op, Funct, Rd, ALUFlags, MemReady,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        input  ImmSrc, RegSrc, ALUControl, State
    );

    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags, MemReady,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        output ImmSrc, RegSrc, ALUControl, State
    );

endinterface

// File: rtl/cond_unit.sv
// NZCV flag register and condition evaluation against the registered flags.
module cond_unit
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       upd_nz,
    input  logic       upd_cv,
    output logic       cond_ex,
    output logic [3:0] flags
);

    logic [3:0] flags_q;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;
    assign flags        = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            CondEq:  cond_ex = z;
            CondNe:  cond_ex = ~z;
            CondCs:  cond_ex = c;
            CondCc:  cond_ex = ~c;
            CondMi:  cond_ex = n;
            CondPl:  cond_ex = ~n;
            CondVs:  cond_ex = v;
            CondVc:  cond_ex = ~v;
            CondHi:  cond_ex = c & ~z;
            CondLs:  cond_ex = ~c | z;
            CondGe:  cond_ex = (n == v);
            CondLt:  cond_ex = (n != v);
            CondGt:  cond_ex = ~z & (n == v);
            CondLe:  cond_ex = z | (n != v);
            CondAl:  cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Only a condition-passing instruction may touch the flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else begin
            if (upd_nz && cond_ex) flags_q[3:2] <= alu_flags[3:2];
            if (upd_cv && cond_ex) flags_q[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset controller: Moore FSM with instruction decode; flags live in cond_unit.
module mc_controller
    import mc_pkg::*;
#(
    parameter bit WAIT_EN = 1'b1
) (
    input logic clk,
    input logic reset,
    mc_if.slave bus
);

    state_e     state_q, state_d;
    logic       memwr_seen_q;
    logic       ready;
    logic [3:0] cmd;
    logic       supported;
    logic [1:0] alu_dec;
    logic       exec;
    logic       cond_ex;
    logic [3:0] flags;

    logic       pc_write, ir_write, reg_write, mem_write;
    logic       adr_src, alu_src_a;
    logic [1:0] alu_src_b, result_src, alu_control;

    assign ready = WAIT_EN ? bus.MemReady : 1'b1;
    assign cmd   = bus.Funct[4:1];
    assign exec  = (state_q == StExecR) || (state_q == StExecI);

    always_comb begin
        alu_dec   = AluAdd;
        supported = 1'b1;
        case (cmd)
            CmdAdd:  alu_dec = AluAdd;
            CmdSub:  alu_dec = AluSub;
            CmdAnd:  alu_dec = AluAnd;
            CmdOrr:  alu_dec = AluOrr;
            default: supported = 1'b0;
        endcase
    end

    cond_unit u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (bus.Cond),
        .alu_flags (bus.ALUFlags),
        .upd_nz    (exec & bus.Funct[0] & supported),
        .upd_cv    (exec & bus.Funct[0] & cmd_is_arith(cmd)),
        .cond_ex   (cond_ex),
        .flags     (flags)
    );

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = ready ? StDecode : StFetch;
            StDecode: begin
                case (bus.Op)
                    OpDp:    state_d = bus.Funct[5] ? StExecI : StExecR;
                    OpMem:   state_d = StMemAdr;
                    OpBr:    state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = bus.Funct[0] ? StMemRd : StMemWr;
            StMemRd:  state_d = ready ? StMemWb : StMemRd;
            StMemWb:  state_d = StFetch;
            StMemWr:  state_d = ready ? StFetch : StMemWr;
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    // memwr_seen_q marks MEMWR cycles after the first, so a stalled store writes once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StFetch;
            memwr_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            memwr_seen_q <= (state_q == StMemWr);
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = AluAdd;
        case (state_q)
            StFetch: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = ready;
                pc_write   = ready;
            end
            StDecode: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            StMemAdr: alu_src_b = 2'b01;
            StMemRd:  adr_src = 1'b1;
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = cond_ex;
            end
            StMemWr: begin
                adr_src   = 1'b1;
                mem_write = cond_ex & ~memwr_seen_q;
            end
            StExecR:  alu_control = alu_dec;
            StExecI: begin
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
            end
            StAluWb: begin
                reg_write = cond_ex & supported;
                pc_write  = cond_ex & (bus.Rd == 4'd15);
            end
            StBranch: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = cond_ex;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so nothing is written while it is held low.
    assign bus.PCWrite    = pc_write & reset;
    assign bus.IRWrite    = ir_write & reset;
    assign bus.RegWrite   = reg_write & reset;
    assign bus.MemWrite   = mem_write & reset;
    assign bus.AdrSrc     = adr_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUControl = alu_control;
    assign bus.ImmSrc     = bus.Op;
    assign bus.RegSrc     = {bus.Op == OpMem, bus.Op == OpBr};
    assign bus.State      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed and randomized checks of mc_controller against a per-instruction expected-cycle list.
module tb_mc_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_if bus ();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    localparam int SF = 0, SD = 1, SMA = 2, SMR = 3, SMWB = 4, SMW = 5;
    localparam int SER = 6, SEI = 7, SWB = 8, SBR = 9;

    int vectors    = 0;
    int miscompares = 0;

    int         q_st[$];
    bit         q_rdy[$];
    logic [3:0] q_strb[$];   // {PCWrite, IRWrite, RegWrite, MemWrite}

    logic [3:0] mflags = 4'b0000;
    logic [3:0] c_cond, c_rd, c_alu;
    logic [1:0] c_op, c_actl;
    logic [5:0] c_funct;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // {mask, value} over {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl}
    function automatic logic [15:0] sel_exp(input int st, input logic [1:0] actl);
        case (st)
            SF:   return {8'hFF, 8'h68};
            SD:   return {8'h7C, 8'h68};
            SMA:  return {8'h73, 8'h10};
            SMR:  return {8'h80, 8'h80};
            SMWB: return {8'h0C, 8'h04};
            SMW:  return {8'h80, 8'h80};
            SER:  return {8'h73, 6'b0, actl};
            SEI:  return {8'h73, 6'b000100, actl};
            SWB:  return {8'h0C, 8'h00};
            default: return {8'h7C, 8'h18};
        endcase
    endfunction

    task automatic push(input int st, input bit rdy, input logic [3:0] strb);
        q_st.push_back(st);
        q_rdy.push_back(rdy);
        q_strb.push_back(strb);
    endtask

    task automatic run_cycles();
        bit         first = 1'b1;
        int         st;
        logic [3:0] strb;
        logic [15:0] se;
        logic [7:0]  sel;
        while (q_st.size() > 0) begin
            @(negedge clk);
            if (first) begin
                bus.Cond = c_cond; bus.Op = c_op; bus.Funct = c_funct;
                bus.Rd = c_rd; bus.ALUFlags = c_alu;
                first = 1'b0;
            end
            bus.MemReady = q_rdy.pop_front();
            #1;
            st   = q_st.pop_front();
            strb = q_strb.pop_front();
            check("state", 32'(bus.State), 32'(st));
            check("strobes", 32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}),
                  32'(strb));
            se  = sel_exp(st, c_actl);
            sel = {bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl};
            check("selects", 32'(sel & se[15:8]), 32'(se[7:0]));
            check("immsrc_regsrc", 32'({bus.ImmSrc, bus.RegSrc}),
                  32'({c_op, c_op == 2'b01, c_op == 2'b10}));
        end
    endtask

    task automatic issue(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] rd, input logic [3:0] alu, input int fs, input int ms);
        bit         ce, sup, arith;
        logic [3:0] cmd;
        c_cond = cond; c_op = op; c_funct = funct; c_rd = rd; c_alu = alu;
        cmd   = funct[4:1];
        sup   = 1'b1;
        arith = (cmd == 4'b0100) || (cmd == 4'b0010);
        case (cmd)
            4'b0100: c_actl = 2'b00;
            4'b0010: c_actl = 2'b01;
            4'b0000: c_actl = 2'b10;
            4'b1100: c_actl = 2'b11;
            default: begin c_actl = 2'b00; sup = 1'b0; end
        endcase
        ce = cond_ok(cond, mflags);
        for (int i = 0; i < fs; i++) push(SF, 1'b0, 4'b0000);
        push(SF, 1'b1, 4'b1100);
        push(SD, 1'($urandom), 4'b0000);
        case (op)
            2'b00: begin
                push(funct[5] ? SEI : SER, 1'($urandom), 4'b0000);
                if (funct[0] && ce && sup) begin
                    mflags[3:2] = alu[3:2];
                    if (arith) mflags[1:0] = alu[1:0];
                end
                ce = cond_ok(cond, mflags);
                push(SWB, 1'($urandom), {ce && (rd == 4'd15), 1'b0, ce && sup, 1'b0});
            end
            2'b01: begin
                push(SMA, 1'($urandom), 4'b0000);
                if (funct[0]) begin
                    for (int i = 0; i < ms; i++) push(SMR, 1'b0, 4'b0000);
                    push(SMR, 1'b1, 4'b0000);
                    push(SMWB, 1'($urandom), {2'b00, ce, 1'b0});
                end else begin
                    for (int i = 0; i <= ms; i++) push(SMW, i == ms, {3'b000, ce && (i == 0)});
                end
            end
            2'b10: push(SBR, 1'($urandom), {ce, 3'b000});
            default: ;
        endcase
        run_cycles();
        check("flags", 32'(dut.flags), 32'(mflags));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [3:0] cmd_tab [5];
        logic [3:0] cmd, cond;
        logic [1:0] op;
        bit         sbit;
        cmd_tab = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0110};

        reset = 1'b0;
        bus.MemReady = 1'b1;
        bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'h00; bus.Rd = 4'h0; bus.ALUFlags = 4'h0;
        #2;
        check("rst_state", 32'(bus.State), 32'(SF));
        check("rst_strobes", 32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}), 0);
        check("rst_selects", 32'({bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                                  bus.ALUControl}), 32'h68);
        check("rst_flags", 32'(dut.flags), 0);
        @(negedge clk);
        @(negedge clk);
        bus.MemReady = 1'b0;
        reset = 1'b1;

        issue(4'hE, 2'b00, 6'b001000, 4'd1, 4'b1111, 0, 0);   // ADD R1,R2,R3
        issue(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0100, 1, 0);   // SUBS -> Z set
        issue(4'h0, 2'b10, 6'b101010, 4'd0, 4'b0000, 0, 0);   // BEQ taken
        issue(4'h1, 2'b10, 6'b010101, 4'd0, 4'b0000, 0, 0);   // BNE not taken
        issue(4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000, 0, 0);  // ADD PC,...
        issue(4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000, 0, 3);   // LDR, 3 stall cycles
        issue(4'hF, 2'b01, 6'b011000, 4'd3, 4'b0000, 0, 0);   // STR never
        issue(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, 0, 0);   // Op=11

        // Store stalled in MEMWR, then aborted by reset.
        c_cond = 4'hE; c_op = 2'b01; c_funct = 6'b011000; c_rd = 4'd4; c_alu = 4'b0000;
        c_actl = 2'b00;
        push(SF, 1'b1, 4'b1100);
        push(SD, 1'b1, 4'b0000);
        push(SMA, 1'b1, 4'b0000);
        push(SMW, 1'b0, 4'b0001);
        run_cycles();
        @(negedge clk);
        bus.MemReady = 1'b0;
        #1;
        check("memwr_second", 32'({bus.State, bus.MemWrite}), 32'({4'd5, 1'b0}));
        reset = 1'b0;
        #1;
        mflags = 4'b0000;
        check("abort_memwrite", 32'(bus.MemWrite), 0);
        check("abort_state", 32'(bus.State), 32'(SF));
        check("abort_flags", 32'(dut.flags), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_state", 32'(bus.State), 32'(SF));
        check("release_strobes", 32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}),
              0);

        for (int k = 0; k < 200; k++) begin
            op   = 2'($urandom_range(0, 3));
            cmd  = cmd_tab[$urandom_range(0, 4)];
            sbit = 1'($urandom);
            cond = 4'($urandom_range(0, 15));
            // Flag-setting data ops use AL/NV so the condition is stable across the instruction.
            if (op == 2'b00 && sbit) cond = ($urandom_range(0, 3) != 0) ? 4'hE : 4'hF;
            issue(cond, op, {1'($urandom), cmd, sbit},
                  ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14)),
                  4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
